// File: rtl/prbs31_checker_ctl.sv
// prbs31_checker_ctl
// Sequencer wrapped around an external PRBS31 generator (LSB-first, same WIDTH)
// so that the pair behaves as a self-synchronising receive checker.
//   IDLE   -> nothing driven to the generator
//   SEED   -> next valid rx word seeds the generator (newest 31 bits)
//   VERIFY -> LOCK_COUNT consecutive clean words are needed to declare lock
//   LOCKED -> every word is checked; UNLOCK_COUNT consecutive bad words drop lock
// Build option: define PRBS_CHK_POPCOUNT_EN to make err_count count bit errors
// (popcount of the mismatch) instead of errored words.
module prbs31_checker_ctl #(
    parameter int WIDTH        = 32,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear_counters,
    input  logic             rx_valid,
    input  logic [WIDTH-1:0] rx_data,
    output logic             prbs_init,
    output logic             prbs_update,
    output logic [30:0]      prbs_seed,
    input  logic [WIDTH-1:0] prbs_dout,
    output logic             locked,
    output logic [31:0]      err_count,
    output logic [47:0]      bit_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEED   = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [7:0]  LOCK_N    = 8'(LOCK_COUNT);
    localparam logic [7:0]  UNLOCK_N  = 8'(UNLOCK_COUNT);
    localparam logic [47:0] WORD_BITS = 48'(WIDTH);

    // Registered state
    logic [1:0]       state_q,       state_d;
    logic             locked_q,      locked_d;
    logic [31:0]      err_count_q,   err_count_d;
    logic [47:0]      bit_count_q,   bit_count_d;
    logic [7:0]       good_cnt_q,    good_cnt_d;
    logic [7:0]       bad_cnt_q,     bad_cnt_d;
    logic             cmp_pending_q, cmp_pending_d;
    logic [WIDTH-1:0] rx_d_q,        rx_d_d;

    // Compare datapath
    logic             in_cmp_state;
    logic [WIDTH-1:0] diff;
    logic             word_err;
    logic [31:0]      err_inc;

    // Saturating adders: counters stick at all-ones rather than wrap
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    function automatic logic [47:0] sat_add48(input logic [47:0] a, input logic [47:0] b);
        logic [48:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[48] ? '1 : s[47:0];
    endfunction

    assign in_cmp_state = (state_q == ST_VERIFY) || (state_q == ST_LOCKED);

    // Generator controls depend only on state and rx_valid, so the generator
    // sees them in the same cycle as the word they refer to
    always_comb begin
        prbs_init   = (state_q == ST_SEED) && rx_valid;
        prbs_update = in_cmp_state && rx_valid;
        prbs_seed   = '0;
        // Seed bit 0 is the newest received bit, i.e. the word's MSB
        if (prbs_init) begin
            for (int k = 0; k < 31; k++) begin
                prbs_seed[k] = rx_data[WIDTH-1-k];
            end
        end
    end

    assign diff     = prbs_dout ^ rx_d_q;
    assign word_err = |diff;

`ifdef PRBS_CHK_POPCOUNT_EN
    // Bit-error weight of the current mismatch
    always_comb begin
        err_inc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            err_inc = err_inc + {31'd0, diff[i]};
        end
    end
`else
    assign err_inc = 32'd1;
`endif

    // Next-state: pending compare first, then the new word, then commands
    always_comb begin
        logic cmp_now;
        logic leave;

        state_d       = state_q;
        err_count_d   = err_count_q;
        bit_count_d   = bit_count_q;
        good_cnt_d    = good_cnt_q;
        bad_cnt_d     = bad_cnt_q;
        cmp_pending_d = 1'b0;
        rx_d_d        = rx_d_q;
        leave         = 1'b0;

        // A start/stop in the compare cycle abandons that compare
        cmp_now = cmp_pending_q && in_cmp_state && !start && !stop;

        if (cmp_now) begin
            if (state_q == ST_VERIFY) begin
                if (word_err) begin
                    state_d = ST_SEED;
                    leave   = 1'b1;
                end else begin
                    good_cnt_d = good_cnt_q + 8'd1;
                    if (good_cnt_q + 8'd1 == LOCK_N) begin
                        state_d   = ST_LOCKED;
                        bad_cnt_d = '0;
                    end
                end
            end else begin
                bit_count_d = sat_add48(bit_count_q, WORD_BITS);
                if (word_err) begin
                    err_count_d = sat_add32(err_count_q, err_inc);
                    bad_cnt_d   = bad_cnt_q + 8'd1;
                    if (bad_cnt_q + 8'd1 == UNLOCK_N) begin
                        state_d = ST_SEED;
                        leave   = 1'b1;
                    end
                end else begin
                    bad_cnt_d = '0;
                end
            end
        end

        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_SEED;
        end else if (rx_valid) begin
            if (state_q == ST_SEED) begin
                state_d    = ST_VERIFY;
                good_cnt_d = '0;
            end else if (in_cmp_state && !leave) begin
                // Word issued while falling back to SEED is dropped
                cmp_pending_d = 1'b1;
                rx_d_d        = rx_data;
            end
        end

        if (clear_counters) begin
            err_count_d = '0;
            bit_count_d = '0;
        end
    end

    assign locked_d = (state_d == ST_LOCKED);

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            locked_q      <= 1'b0;
            err_count_q   <= '0;
            bit_count_q   <= '0;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            cmp_pending_q <= 1'b0;
            rx_d_q        <= '0;
        end else begin
            state_q       <= state_d;
            locked_q      <= locked_d;
            err_count_q   <= err_count_d;
            bit_count_q   <= bit_count_d;
            good_cnt_q    <= good_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            cmp_pending_q <= cmp_pending_d;
            rx_d_q        <= rx_d_d;
        end
    end

    assign locked    = locked_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs31_checker_ctl.sv
// Bench for prbs31_checker_ctl: WIDTH=32, LOCK_COUNT=4, UNLOCK_COUNT=3.
// Contains a behavioural PRBS31 generator wired to the DUT and a word-level
// reference model of the lock/counter rules.
module tb_prbs31_checker_ctl;

    localparam int W      = 32;
    localparam int LOCKN  = 4;
    localparam int ULOCKN = 3;

    localparam int M_IDLE = 0, M_SEED = 1, M_VERIFY = 2, M_LOCKED = 3;

    logic          clk, rst;
    logic          start, stop, clear_counters, rx_valid;
    logic [W-1:0]  rx_data;
    logic          prbs_init, prbs_update;
    logic [30:0]   prbs_seed;
    logic [W-1:0]  prbs_dout;
    logic          locked;
    logic [31:0]   err_count;
    logic [47:0]   bit_count;

    int total = 0;
    int bad   = 0;

    prbs31_checker_ctl #(.WIDTH(W), .LOCK_COUNT(LOCKN), .UNLOCK_COUNT(ULOCKN)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .clear_counters(clear_counters), .rx_valid(rx_valid), .rx_data(rx_data),
        .prbs_init(prbs_init), .prbs_update(prbs_update), .prbs_seed(prbs_seed),
        .prbs_dout(prbs_dout), .locked(locked), .err_count(err_count),
        .bit_count(bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PRBS31 x^31+x^28+1; h[0] newest bit, h[k] is k+1 bits old.
    // Emits 32 bits, bit 0 oldest.
    function automatic bit [31:0] prbs_word(inout bit [30:0] h);
        bit [31:0] w;
        bit b;
        w = '0;
        for (int i = 0; i < W; i++) begin
            b    = h[30] ^ h[27];
            w[i] = b;
            h    = {h[29:0], b};
        end
        return w;
    endfunction

    function automatic bit [30:0] seed_of(input bit [31:0] w);
        bit [30:0] s;
        for (int k = 0; k < 31; k++) s[k] = w[W-1-k];
        return s;
    endfunction

    function automatic bit [31:0] flip_mask(input int n);
        bit [31:0] m;
        m = '0;
        while ($countones(m) < n) m[$urandom_range(0, W-1)] = 1'b1;
        return m;
    endfunction

    // External generator: init loads state, update emits next word registered
    bit [30:0] gen_st;
    always @(posedge clk or posedge rst) begin : gen_blk
        bit [30:0] t;
        bit [31:0] w;
        if (rst) begin
            gen_st    <= '0;
            prbs_dout <= '0;
        end else if (prbs_init) begin
            gen_st <= prbs_seed;
        end else if (prbs_update) begin
            t = gen_st;
            w = prbs_word(t);
            gen_st    <= t;
            prbs_dout <= w;
        end
    end

    // Reference model (word level)
    int        m_mode;
    bit [30:0] m_hist;
    bit        m_pend;
    int        m_perr;
    int        m_good, m_bad;
    bit [31:0] m_err;
    bit [47:0] m_bits;
    bit        m_locked;
    bit [30:0] src;

    task automatic model_reset();
        m_mode = M_IDLE; m_hist = '0; m_pend = 0; m_perr = 0;
        m_good = 0; m_bad = 0; m_err = '0; m_bits = '0; m_locked = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_cycle(input bit v, input bit [31:0] d, input bit st, input bit sp, input bit clr);
        int  nmode;
        bit  leave;
        longint unsigned s;
        longint unsigned inc;
        bit [31:0] ew;
        nmode = m_mode;
        leave = 0;
        if (m_pend && m_mode >= M_VERIFY && !st && !sp) begin
            if (m_mode == M_VERIFY) begin
                if (m_perr != 0) begin
                    nmode = M_SEED; leave = 1;
                end else begin
                    m_good++;
                    if (m_good == LOCKN) begin nmode = M_LOCKED; m_bad = 0; end
                end
            end else begin
                s = longint'(m_bits) + W;
                m_bits = (s > 64'hFFFF_FFFF_FFFF) ? '1 : s[47:0];
                if (m_perr != 0) begin
`ifdef PRBS_CHK_POPCOUNT_EN
                    inc = longint'(m_perr);
`else
                    inc = 1;
`endif
                    s = longint'(m_err) + inc;
                    m_err = (s > 64'hFFFF_FFFF) ? '1 : s[31:0];
                    m_bad++;
                    if (m_bad == ULOCKN) begin nmode = M_SEED; leave = 1; end
                end else begin
                    m_bad = 0;
                end
            end
        end
        m_pend = 0;
        if (sp) nmode = M_IDLE;
        else if (st) nmode = M_SEED;
        else if (v) begin
            if (m_mode == M_SEED) begin
                m_hist = seed_of(d); m_good = 0; nmode = M_VERIFY;
            end else if (m_mode >= M_VERIFY && !leave) begin
                ew = prbs_word(m_hist);
                m_pend = 1;
                m_perr = $countones(ew ^ d);
            end
        end
        if (clr) begin m_err = '0; m_bits = '0; end
        m_mode   = nmode;
        m_locked = (nmode == M_LOCKED);
    endtask

    // One clock: drive at posedge+1, check combinational outputs, clock, check registers
    task automatic step(input bit v, input bit [31:0] d, input bit st, input bit sp, input bit clr);
        bit e_init, e_upd;
        rx_valid = v; rx_data = v ? d : $urandom();
        start = st; stop = sp; clear_counters = clr;
        #1;
        e_init = (m_mode == M_SEED) && v;
        e_upd  = (m_mode >= M_VERIFY) && v;
        chk("prbs_init", 64'(prbs_init), 64'(e_init));
        chk("prbs_update", 64'(prbs_update), 64'(e_upd));
        if (e_init) chk("prbs_seed", 64'(prbs_seed), 64'(seed_of(d)));
        model_cycle(v, d, st, sp, clr);
        @(posedge clk); #1;
        chk("locked", 64'(locked), 64'(m_locked));
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("bit_count", 64'(bit_count), 64'(m_bits));
        rx_valid = 0; start = 0; stop = 0; clear_counters = 0;
    endtask

    task automatic send(input int flips, input bit clr);
        bit [31:0] d;
        d = prbs_word(src) ^ flip_mask(flips);
        step(1'b1, d, 1'b0, 1'b0, clr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bit [31:0] sv_err;
        bit [47:0] sv_bits;
        int        sent;
        int        ph;
        rst = 1'b1; start = 0; stop = 0; clear_counters = 0;
        rx_valid = 0; rx_data = '0;
        src = 31'h1;
        model_reset();
        #12;
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_bits", 64'(bit_count), 64'd0);
        chk("rst_init", 64'(prbs_init), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: clean lock
        do_start();
        for (int i = 0; i < 6; i++) send(0, 0);
        idle(2);
        chk("t1_locked", 64'(locked), 64'd1);
        chk("t1_err", 64'(err_count), 64'd0);

        // 2: three bit errors in one word while locked
        sv_err = m_err;
        send(3, 0);
        for (int i = 0; i < 3; i++) send(0, 0);
        idle(2);
`ifdef PRBS_CHK_POPCOUNT_EN
        chk("t2_err", 64'(err_count), 64'(sv_err) + 3);
`else
        chk("t2_err", 64'(err_count), 64'(sv_err) + 1);
`endif
        chk("t2_locked", 64'(locked), 64'd1);

        // 3: unlock after three consecutive errored words, then relock
        for (int i = 0; i < 3; i++) send(1, 0);
        idle(2);
        chk("t3_unlocked", 64'(locked), 64'd0);
        for (int i = 0; i < 6; i++) send(0, 0);
        idle(2);
        chk("t3_relocked", 64'(locked), 64'd1);

        // 4: verify failure on word 2 after seeding
        sv_err = m_err; sv_bits = m_bits;
        do_start();
        send(0, 0); send(0, 0); send(2, 0);
        for (int i = 0; i < 8; i++) send(0, 0);
        chk("t4_err_hold", 64'(err_count), 64'(sv_err));
        idle(2);
        chk("t4_locked", 64'(locked), 64'd1);

        // 5: 1-of-3 gaps, then saturation of both counters
        do_start();
        sent = 0;
        ph = 0;
        while (sent < 6) begin
            if (ph == 0) begin send(0, 0); sent++; end
            else idle(1);
            ph = (ph + 1) % 3;
        end
        idle(2);
        chk("t5_gap_lock", 64'(locked), 64'd1);
        force dut.err_count_q = 32'hFFFF_FFFD;
        force dut.bit_count_q = 48'hFFFF_FFFF_FFC0;
        #1;
        release dut.err_count_q;
        release dut.bit_count_q;
        m_err = 32'hFFFF_FFFD; m_bits = 48'hFFFF_FFFF_FFC0;
        for (int i = 0; i < 4; i++) begin send(3, 0); send(0, 0); end
        idle(2);
        chk("t5_err_sat", 64'(err_count), 64'hFFFF_FFFF);
        chk("t5_bits_sat", 64'(bit_count), 64'hFFFF_FFFF_FFFF);

        // Random traffic: gaps, sparse bit errors, occasional clears
        do_start();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send(($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 4)) : 0,
                      $urandom_range(0, 60) == 0);
        end
        idle(2);

        // 6: stop wins over start, clear beats increment, async reset
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        send(0, 0);
        chk("t6_idle_locked", 64'(locked), 64'd0);
        do_start();
        for (int i = 0; i < 6; i++) send(0, 0);
        idle(1);
        send(2, 0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("t6_clr_err", 64'(err_count), 64'd0);
        chk("t6_clr_bits", 64'(bit_count), 64'd0);
        for (int i = 0; i < 3; i++) send(0, 0);
        idle(2);
        chk("t6_pre_rst_locked", 64'(locked), 64'd1);
        rx_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("t6_rst_locked", 64'(locked), 64'd0);
        chk("t6_rst_err", 64'(err_count), 64'd0);
        chk("t6_rst_bits", 64'(bit_count), 64'd0);
        chk("t6_rst_update", 64'(prbs_update), 64'd0);
        chk("t6_rst_init", 64'(prbs_init), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0; rx_valid = 1'b0;
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
